// File: rtl/sp_ram_read_first.sv
// Single-port synchronous RAM with read-first behaviour.
// The read and the write share one enable, so the output register only
// updates on cycles that actually access the RAM. This pattern maps to
// BRAM or LUTRAM with a registered output.
module sp_ram_read_first #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 99,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Capture the old word before overwriting it, on enabled cycles only.
  always_ff @(posedge clk) begin
    if (we) begin
      dout      <= mem[addr];
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/ram_based_delay_line.sv
// Fixed-latency delay line. Its output matches a chain of DELAY
// zero-initialised registers. For DELAY >= 2 the samples are kept in a
// circular buffer of DELAY-1 RAM words, followed by the RAM output register.
module ram_based_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY      = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int ADDR_WIDTH = (DELAY <= 2) ? 1 : $clog2(DELAY - 1);

  generate
    if (DELAY == 1) begin : g_reg

      logic [DATA_WIDTH-1:0] out_q = '0;

      // A single enabled register is the whole delay line.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else if (ce) begin
          out_q <= data_in;
        end
      end

      assign data_out = out_q;

    end else begin : g_ram

      localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DELAY - 2);

      logic [ADDR_WIDTH-1:0] wr_ptr  = '0;
      logic                  filled  = 1'b0;
      logic                  valid_q = 1'b0;
      logic [DATA_WIDTH-1:0] ram_dout;

      sp_ram_read_first #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DELAY - 1),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
        .clk  (clk),
        .we   (ce),
        .addr (wr_ptr),
        .din  (data_in),
        .dout (ram_dout)
      );

      // Advance the circular pointer. Mark the buffer full on the first wrap.
      // valid_q records whether the word just read was written since reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr  <= '0;
          filled  <= 1'b0;
          valid_q <= 1'b0;
        end else if (ce) begin
          valid_q <= filled;
          if (wr_ptr == LAST_ADDR) begin
            wr_ptr <= '0;
            filled <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
      end

      // The RAM output register is the data register. Words left over from
      // before reset are masked to zero until the buffer has refilled.
      assign data_out = valid_q ? ram_dout : '0;

    end
  endgenerate

endmodule

// File: tb/tb_ram_based_delay_line.sv
// Self-checking bench for ram_based_delay_line. Five instances with
// different DELAY values share one stimulus bus. A queue holds every enabled
// sample since the last reset. The expected output for delay D is the D-th
// newest entry of that queue, or 0 while fewer than D samples exist.
module tb_ram_based_delay_line;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] out100, out1, out2, out5, out4;

  int checks = 0;
  int passes = 0;

  int delays [5] = '{100, 1, 2, 5, 4};
  logic [7:0] hist [$];

  always #5 clk = ~clk;

  ram_based_delay_line #(.DATA_WIDTH(8), .DELAY(100)) dut100 (
    .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .data_out(out100));
  ram_based_delay_line #(.DATA_WIDTH(8), .DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .data_out(out1));
  ram_based_delay_line #(.DATA_WIDTH(8), .DELAY(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .data_out(out2));
  ram_based_delay_line #(.DATA_WIDTH(8), .DELAY(5)) dut5 (
    .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .data_out(out5));
  ram_based_delay_line #(.DATA_WIDTH(8), .DELAY(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .data_out(out4));

  // Expected output for a line of delay d, from the sample history.
  function automatic logic [7:0] expected(int d);
    int n = hist.size();
    if (n >= d) return hist[n - d];
    return 8'h00;
  endfunction

  // Selects the output of instance k, in the order of the delays table.
  function automatic logic [7:0] actual(int k);
    case (k)
      0:       return out100;
      1:       return out1;
      2:       return out2;
      3:       return out5;
      default: return out4;
    endcase
  endfunction

  // Drives one cycle on the falling edge and updates the model at the rising edge.
  // Outputs are then left to settle for 1 time unit before the caller samples them.
  task automatic step(input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    ce = c;
    data_in = d;
    @(posedge clk);
    if (r) hist.delete();
    else if (c) hist.push_back(d);
    #1;
  endtask

  // Power-up state: the lines behave as if just reset. Then reset while ce=0.
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'(8'h40 + i));
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (actual(k) !== expected(delays[k]))
          $display("[TB] FAIL powerup d=%0d got %h want %h", delays[k], actual(k), expected(delays[k]));
        else passes++;
      end
    end
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (actual(k) !== 8'h00)
        $display("[TB] FAIL reset d=%0d got %h want 00", delays[k], actual(k));
      else passes++;
    end
  endtask

  // Incrementing counter through DELAY=100, including the 255->0 wrap.
  task automatic test_counter_d100();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 360; i++) begin
      step(1'b0, 1'b1, 8'(i));
      checks++;
      if (out100 !== expected(100))
        $display("[TB] FAIL counter100 i=%0d got %h want %h", i, out100, expected(100));
      else passes++;
      if (i < 99) begin
        checks++;
        if (out100 !== 8'h00)
          $display("[TB] FAIL fill100 i=%0d got %h want 00", i, out100);
        else passes++;
      end
    end
  endtask

  // DELAY=1 and DELAY=2 lag by one and two enabled cycles.
  task automatic test_short_delays();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'(8'h11 + i));
      if (i == 0) begin
        checks++;
        if (out1 !== 8'h11) $display("[TB] FAIL d1_first got %h want 11", out1);
        else passes++;
        checks++;
        if (out2 !== 8'h00) $display("[TB] FAIL d2_first got %h want 00", out2);
        else passes++;
      end
      if (i == 1) begin
        checks++;
        if (out2 !== 8'h11) $display("[TB] FAIL d2_second got %h want 11", out2);
        else passes++;
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (actual(k) !== expected(delays[k]))
          $display("[TB] FAIL short d=%0d i=%0d got %h want %h", delays[k], i, actual(k), expected(delays[k]));
        else passes++;
      end
    end
  endtask

  // Alternating ce on DELAY=5. The output must hold while ce is low.
  task automatic test_ce_toggle();
    logic [7:0] cnt = 8'h01;
    logic [7:0] prev;
    logic       c;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) begin
      c = (i % 2 == 0);
      prev = out5;
      step(1'b0, c, c ? cnt : 8'hAA);
      if (c) cnt++;
      checks++;
      if (out5 !== expected(5))
        $display("[TB] FAIL ce_toggle i=%0d got %h want %h", i, out5, expected(5));
      else passes++;
      if (!c) begin
        checks++;
        if (out5 !== prev)
          $display("[TB] FAIL ce_hold i=%0d got %h want %h", i, out5, prev);
        else passes++;
      end
    end
  endtask

  // Reset after 20 enabled cycles discards every in-flight sample.
  task automatic test_mid_reset();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom_range(1, 255)));
    step(1'b1, 1'b1, 8'h77);
    checks++;
    if (out5 !== 8'h00) $display("[TB] FAIL mid_reset got %h want 00", out5);
    else passes++;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'(8'hC0 + i));
      if (i < 4) begin
        checks++;
        if (out5 !== 8'h00)
          $display("[TB] FAIL refill5 i=%0d got %h want 00", i, out5);
        else passes++;
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (actual(k) !== expected(delays[k]))
          $display("[TB] FAIL after_reset d=%0d i=%0d got %h want %h", delays[k], i, actual(k), expected(delays[k]));
        else passes++;
      end
    end
  endtask

  // Reset takes effect even while ce is low.
  task automatic test_reset_no_ce();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'($urandom_range(1, 255)));
    step(1'b1, 1'b0, 8'h55);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (actual(k) !== 8'h00)
        $display("[TB] FAIL reset_no_ce d=%0d got %h want 00", delays[k], actual(k));
      else passes++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i > 2), 8'(8'h90 + i));
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (actual(k) !== expected(delays[k]))
          $display("[TB] FAIL post_reset_no_ce d=%0d i=%0d got %h want %h", delays[k], i, actual(k), expected(delays[k]));
        else passes++;
      end
    end
  endtask

  // Random data and random ce, checked on every instance with DELAY=4 in focus.
  task automatic test_random_d4();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (actual(k) !== expected(delays[k]))
          $display("[TB] FAIL random d=%0d i=%0d got %h want %h", delays[k], i, actual(k), expected(delays[k]));
        else passes++;
      end
    end
  endtask

  // Runs every scenario in sequence, then prints the summary line.
  initial begin
    $display("[TB] starting ram_based_delay_line bench");
    test_reset();
    test_counter_d100();
    test_short_delays();
    test_ce_toggle();
    test_mid_reset();
    test_reset_no_ce();
    test_random_d4();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
